// File: rtl/task_executor_if.sv
// Dispatch and status bundle between the deadline scheduler (master) and
// the task executor (slave).
interface task_executor_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          task_scheduled;
  logic [31:0]   scheduled_task_id;
  logic          busy;
  logic          exec_start;
  logic [31:0]   exec_task_id;
  logic          exec_done;
  logic [31:0]   done_task_id;
  logic [31:0]   done_latency;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [7:0]    drop_count;

  modport master (
    output task_scheduled, scheduled_task_id,
    input  busy, exec_start, exec_task_id, exec_done, done_task_id,
           done_latency, fifo_count, overflow, drop_count
  );

  modport slave (
    input  task_scheduled, scheduled_task_id,
    output busy, exec_start, exec_task_id, exec_done, done_task_id,
           done_latency, fifo_count, overflow, drop_count
  );
endinterface

// File: rtl/task_executor.sv
// Buffers scheduler dispatches in a small FIFO and runs them one at a time
// for EXEC_CYCLES cycles each, reporting start, completion and latency.
module task_executor #(
  parameter int FIFO_DEPTH  = 4,
  parameter int EXEC_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  task_executor_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] ctr_q, ctr_d;
  logic [31:0]   now_q, now_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          exec_start_q, exec_start_d;
  logic          exec_done_q, exec_done_d;
  logic [31:0]   exec_id_q, exec_id_d;
  logic [31:0]   done_id_q, done_id_d;
  logic [31:0]   done_lat_q, done_lat_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;

  logic complete;
  logic pop;
  logic accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ctr_q        <= '0;
      now_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      exec_start_q <= 1'b0;
      exec_done_q  <= 1'b0;
      exec_id_q    <= '0;
      done_id_q    <= '0;
      done_lat_q   <= '0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      now_q        <= now_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      exec_start_q <= exec_start_d;
      exec_done_q  <= exec_done_d;
      exec_id_q    <= exec_id_d;
      done_id_q    <= done_id_d;
      done_lat_q   <= done_lat_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    now_d        = now_q + 32'd1;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    exec_start_d = 1'b0;
    exec_done_d  = 1'b0;
    exec_id_d    = exec_id_q;
    done_id_d    = done_id_q;
    done_lat_d   = done_lat_q;
    overflow_d   = overflow_q;
    drop_d       = drop_q;

    complete = (state_q == RUN) && (ctr_q == '0);
    pop      = (count_q != '0) && ((state_q == IDLE) || complete);
    // A full FIFO still takes a dispatch when the head leaves on the same edge.
    accept   = bus.task_scheduled && ((count_q != FULL) || pop);
    count_d  = count_q + CW'(accept) - CW'(pop);

    if (accept) begin
      mem_d[wr_ptr_q] = bus.scheduled_task_id;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else if (bus.task_scheduled) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: ;
      RUN: begin
        if (ctr_q != '0) begin
          ctr_d = ctr_q - TW'(1);
        end else begin
          exec_done_d = 1'b1;
          done_id_d   = exec_id_q;
          done_lat_d  = now_q - exec_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      exec_start_d = 1'b1;
      exec_id_d    = mem_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + AW'(1);
      ctr_d        = RELOAD;
      state_d      = RUN;
    end
  end

  assign bus.busy         = (state_q == RUN);
  assign bus.exec_start   = exec_start_q;
  assign bus.exec_task_id = exec_id_q;
  assign bus.exec_done    = exec_done_q;
  assign bus.done_task_id = done_id_q;
  assign bus.done_latency = done_lat_q;
  assign bus.fifo_count   = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.drop_count   = drop_q;
endmodule

// File: tb/tb_task_executor.sv
// Bench for task_executor: cycle tables for the default build, hand sequences
// for overflow and single-cycle execution, and an ID/latency scoreboard.
module tb_task_executor;
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cyc;
  int          checks = 0;
  int          errors = 0;
  bit          mute_b = 1'b0;

  always #5 clk = ~clk;

  task_executor_if #(.FIFO_DEPTH(4)) ifa ();
  task_executor_if #(.FIFO_DEPTH(4)) ifb ();
  task_executor_if #(.FIFO_DEPTH(2)) ifc ();

  task_executor #(.FIFO_DEPTH(4), .EXEC_CYCLES(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  task_executor #(.FIFO_DEPTH(4), .EXEC_CYCLES(8)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  task_executor #(.FIFO_DEPTH(2), .EXEC_CYCLES(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // Bench copy of the scheduler time base: equals the DUT's pre-edge "now" plus one after each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  typedef struct {
    int          dut;
    logic [31:0] id;
  } sb_t;

  typedef struct {
    bit          strobe;
    logic [31:0] id;
    bit          busy;
    bit          start;
    bit          done;
    int          fifo;
  } vec_t;

  sb_t  start_q[$];
  sb_t  done_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void expectTask(input int dut, input logic [31:0] id);
    start_q.push_back('{dut, id});
    done_q.push_back('{dut, id});
  endfunction

  function automatic int pendingCount(input int dut);
    int n = 0;
    foreach (done_q[i]) if (done_q[i].dut == dut) n++;
    return n;
  endfunction

  task automatic scoreStart(input int dut, input logic [31:0] id);
    int idx = -1;
    foreach (start_q[i]) if (idx < 0 && start_q[i].dut == dut) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_start dut%0d actual=%0h required=none", dut, id);
    end else begin
      check($sformatf("start_id_dut%0d", dut), id, start_q[idx].id);
      start_q.delete(idx);
    end
  endtask

  task automatic scoreDone(input int dut, input logic [31:0] id, input logic [31:0] lat);
    int idx = -1;
    foreach (done_q[i]) if (idx < 0 && done_q[i].dut == dut) idx = i;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_done dut%0d actual=%0h required=none", dut, id);
    end else begin
      check($sformatf("done_id_dut%0d", dut), id, done_q[idx].id);
      check($sformatf("done_lat_dut%0d", dut), lat, (cyc - 32'd1) - done_q[idx].id);
      done_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.exec_start) scoreStart(0, ifa.exec_task_id);
      if (ifa.exec_done)  scoreDone(0, ifa.done_task_id, ifa.done_latency);
      if (ifb.exec_start && !mute_b) scoreStart(1, ifb.exec_task_id);
      if (ifb.exec_done && !mute_b)  scoreDone(1, ifb.done_task_id, ifb.done_latency);
      if (ifc.exec_start) scoreStart(2, ifc.exec_task_id);
      if (ifc.exec_done)  scoreDone(2, ifc.done_task_id, ifc.done_latency);
    end
  end

  task automatic applyStimulus(input int dut, input bit s, input logic [31:0] id, input bit track);
    @(negedge clk);
    case (dut)
      0: begin ifa.task_scheduled = s; ifa.scheduled_task_id = id; end
      1: begin ifb.task_scheduled = s; ifb.scheduled_task_id = id; end
      default: begin ifc.task_scheduled = s; ifc.scheduled_task_id = id; end
    endcase
    if (s && track) expectTask(dut, id);
    @(posedge clk);
    #1;
    ifa.task_scheduled = 1'b0;
    ifb.task_scheduled = 1'b0;
    ifc.task_scheduled = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    check($sformatf("row%0d_busy", row), ifa.busy, v.busy);
    check($sformatf("row%0d_start", row), ifa.exec_start, v.start);
    check($sformatf("row%0d_done", row), ifa.exec_done, v.done);
    check($sformatf("row%0d_fifo", row), ifa.fifo_count, v.fifo);
  endtask

  function automatic void addVec(input bit s, input logic [31:0] id, input bit b,
                                 input bit st, input bit d, input int f);
    vecs.push_back('{s, id, b, st, d, f});
  endfunction

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(0, vecs[i].strobe, vecs[i].id, 1'b1);
      checkOutput(vecs[i], i);
    end
  endtask

  task automatic checkAZero(input string tag);
    check({tag, "_busy"}, ifa.busy, 0);
    check({tag, "_start"}, ifa.exec_start, 0);
    check({tag, "_done"}, ifa.exec_done, 0);
    check({tag, "_exec_id"}, ifa.exec_task_id, 0);
    check({tag, "_done_id"}, ifa.done_task_id, 0);
    check({tag, "_latency"}, ifa.done_latency, 0);
    check({tag, "_fifo"}, ifa.fifo_count, 0);
    check({tag, "_overflow"}, ifa.overflow, 0);
    check({tag, "_drops"}, ifa.drop_count, 0);
  endtask

  initial begin
    logic [31:0] n0;
    ifa.task_scheduled = 1'b0; ifa.scheduled_task_id = '0;
    ifb.task_scheduled = 1'b0; ifb.scheduled_task_id = '0;
    ifc.task_scheduled = 1'b0; ifc.scheduled_task_id = '0;

    // Rows 0-16: isolated ID 5 sampled at now=10 (rows index the pre-edge now).
    for (int i = 0; i < 10; i++) addVec(0, 0, 0, 0, 0, 0);
    addVec(1, 5, 0, 0, 0, 1);
    addVec(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0);
    // Rows 17-31: IDs 20, 21, 22 on consecutive edges, back-to-back execution.
    addVec(1, 20, 0, 0, 0, 1);
    addVec(1, 21, 1, 1, 0, 1);
    addVec(1, 22, 1, 0, 0, 2);
    addVec(0, 0, 1, 0, 0, 2);
    addVec(0, 0, 1, 0, 0, 2);
    addVec(0, 0, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, 1);
    addVec(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0);
    // Rows 32-38: isolated ID 7 right after a mid-run reset.
    addVec(1, 7, 0, 0, 0, 1);
    addVec(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkAZero("reset");
    check("reset_b_drops", ifb.drop_count, 0);
    check("reset_c_fifo", ifc.fifo_count, 0);
    reset = 1'b0;

    runVectors(0, 32);

    $display("[TB] wrap-around latency");
    applyStimulus(0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    n0 = cyc - 32'd1;
    repeat (5) applyStimulus(0, 1'b0, 0, 1'b0);
    check("wrap_done", ifa.exec_done, 1);
    check("wrap_latency", ifa.done_latency, n0 + 32'd7);
    applyStimulus(0, 1'b0, 0, 1'b0);

    $display("[TB] reset during RUN with two queued");
    applyStimulus(0, 1'b1, 40, 1'b1);
    applyStimulus(0, 1'b1, 41, 1'b1);
    applyStimulus(0, 1'b1, 42, 1'b1);
    check("pre_reset_busy", ifa.busy, 1);
    check("pre_reset_fifo", ifa.fifo_count, 2);
    #2 reset = 1'b1;
    #1 checkAZero("midrun");
    start_q.delete();
    done_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    runVectors(32, 39);

    $display("[TB] overflow and full-FIFO push with pop");
    applyStimulus(1, 1'b1, 100, 1'b1);
    check("ovf_fifo_first", ifb.fifo_count, 1);
    applyStimulus(1, 1'b0, 0, 1'b0);
    check("ovf_started", ifb.exec_start, 1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1'b1, 101 + k, k < 4);
      if (k == 3) begin
        check("ovf_fifo_full", ifb.fifo_count, 4);
        check("ovf_flag_before", ifb.overflow, 0);
        check("ovf_drops_before", ifb.drop_count, 0);
      end
    end
    check("ovf_fifo_after", ifb.fifo_count, 4);
    check("ovf_flag", ifb.overflow, 1);
    check("ovf_drops", ifb.drop_count, 2);
    applyStimulus(1, 1'b0, 0, 1'b0);
    applyStimulus(1, 1'b1, 107, 1'b1);
    check("fullpop_done", ifb.exec_done, 1);
    check("fullpop_start", ifb.exec_start, 1);
    check("fullpop_fifo", ifb.fifo_count, 4);
    check("fullpop_drops", ifb.drop_count, 2);
    repeat (50) applyStimulus(1, 1'b0, 0, 1'b0);
    check("ovf_drained_busy", ifb.busy, 0);
    check("ovf_pending", pendingCount(1), 0);
    check("ovf_sticky", ifb.overflow, 1);

    $display("[TB] single-cycle execution");
    applyStimulus(2, 1'b1, 200, 1'b1);
    check("c0_fifo", ifc.fifo_count, 1);
    check("c0_busy", ifc.busy, 0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(2, k <= 3, 200 + k, 1'b1);
      check($sformatf("c%0d_start", k), ifc.exec_start, k <= 4);
      check($sformatf("c%0d_done", k), ifc.exec_done, k >= 2 && k <= 5);
      check($sformatf("c%0d_busy", k), ifc.busy, k <= 4);
      check($sformatf("c%0d_fifo", k), ifc.fifo_count, (k <= 3) ? 1 : 0);
    end
    check("all_pending", done_q.size(), 0);

    $display("[TB] drop counter saturation");
    mute_b = 1'b1;
    for (int k = 0; k < 300; k++) applyStimulus(1, 1'b1, 1000 + k, 1'b0);
    check("sat_drops", ifb.drop_count, 255);
    check("sat_overflow", ifb.overflow, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/task_executor.md
# task_executor

Consumer end of the deadline scheduler's dispatch interface. Each `task_scheduled` pulse with its `scheduled_task_id` goes into a small FIFO, because the scheduler cannot be back-pressured. Queued tasks are executed one at a time for a fixed number of cycles. For each task the block reports start, completion, and response latency: completion time minus the task ID, where the ID is the submission timestamp.

## Interface
- `FIFO_DEPTH`, 4: pending-task buffer depth; power of two, ≥2.
- `EXEC_CYCLES`, 4: cycles each task occupies the executor; ≥1.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `task_scheduled` in 1: one-cycle dispatch strobe from scheduler.
- `scheduled_task_id` in 32: task ID (submission timestamp), valid with strobe.
- `busy` out 1: executor holds a task.
- `exec_start` out 1: one-cycle pulse, task popped and started.
- `exec_task_id` out 32: ID of task in execution; held until next start.
- `exec_done` out 1: one-cycle pulse, task finished.
- `done_task_id` out 32: ID of finished task; valid with `exec_done`, held after.
- `done_latency` out 32: response latency of finished task; valid with `exec_done`, held after.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: pending tasks, excluding the one executing.
- `overflow` out 1: sticky, set when a dispatch is dropped.
- `drop_count` out 8: dropped dispatches, saturates at 255.

## Operation
- Local time counter `now`, 32 bit.
  - 0 at reset; +1 every cycle; wraps modulo 2^32.
  - Tracks the scheduler's time base.
  - All arithmetic uses the pre-edge value of `now`.
- Push: on an edge with `task_scheduled`=1, `scheduled_task_id` is written to the FIFO tail.
- Capacity check uses the pre-edge count minus any pop on the same edge.
  - Push and pop on the same edge with the FIFO full: push accepted, count unchanged.
  - Full with no pop: dispatch dropped, `overflow`←1, `drop_count` increments (saturating).
- No bypass: a task pushed at edge E is poppable no earlier than edge E+1.
- FSM has two states, IDLE and RUN.
- IDLE:
  - FIFO empty: stay in IDLE.
  - FIFO non-empty: pop head, `exec_task_id`←head, `exec_start`=1, cycle counter←EXEC_CYCLES−1, go to RUN.
- RUN, counter ≠ 0: decrement.
- RUN, counter = 0, completion:
  - `exec_done`=1, `done_task_id`←`exec_task_id`, `done_latency`←now−`exec_task_id` (mod 2^32).
  - FIFO non-empty: same edge pops the next task, `exec_start`=1, counter reloads, stay in RUN (back-to-back).
  - FIFO empty: go to IDLE.
- `busy`=1 exactly while in RUN.
- Tasks complete in FIFO order; the executor does no re-prioritisation.
- Reset asserted mid-operation:
  - All state and outputs go to 0 immediately.
  - The in-flight task and queued tasks are discarded; no `exec_done` is produced for them.

## Timing
- Reset values: `busy`, `exec_start`, `exec_done`, `overflow` = 0; `exec_task_id`, `done_task_id`, `done_latency` = 0; `fifo_count` = 0; `drop_count` = 0; `now` = 0; FSM in IDLE.
- Isolated task, strobe sampled at edge E (executor idle, FIFO empty):
  - `fifo_count`=1 after E.
  - `exec_start`, `busy`=1 after E+1; `fifo_count`=0.
  - `exec_done` after E+1+EXEC_CYCLES.
  - `busy` falls after E+1+EXEC_CYCLES, having been high for exactly EXEC_CYCLES cycles.
- Back-to-back tasks:
  - `exec_done` and `exec_start` are asserted in the same cycle.
  - `busy` stays high.
  - Throughput is one task per EXEC_CYCLES cycles.
- EXEC_CYCLES=1: each task finishes on the edge after its start. With a full FIFO, `exec_start` and `exec_done` pulse every cycle.
- Pulses (`exec_start`, `exec_done`) last exactly one cycle; there is no handshake back to the scheduler.
- `overflow` clears only on reset.

## Test plan
- Reset, then `task_scheduled` with ID=5 sampled at the edge where now=10, EXEC_CYCLES=4.
  - `exec_start` after the now=11 edge.
  - `exec_done` after the now=15 edge, with `done_task_id`=5 and `done_latency`=10.
  - `busy` high for 4 cycles.
- Three strobes on consecutive edges (IDs 20, 21, 22) while idle.
  - Starts occur 4 cycles apart.
  - `exec_done`/`exec_start` coincide, `busy` is continuously high, completion order is 20, 21, 22.
- FIFO_DEPTH=4, executor busy, 6 strobes on consecutive edges with no pop in between.
  - First 4 accepted, `fifo_count`=4.
  - 2 dropped: `overflow`=1, `drop_count`=2.
  - Later accepted tasks are processed normally.
- Strobe on the same edge as a completion pop with FIFO full: accepted, `fifo_count` unchanged, no drop.
- Wrap-around: ID=0xFFFFFFFE completes when now=0x00000003 → `done_latency`=5.
- Reset asserted 2 cycles into RUN with 2 tasks queued.
  - All outputs read 0 immediately.
  - No `exec_done` for the discarded tasks.
  - A new strobe after release is handled with the isolated-task timing.
